// File: rtl/cnn_mac_pipe_sat_if.sv
// Streaming bus for cnn_mac_pipe_sat.
//   master: drives ce, in_valid, din0, din1, first, last; receives dout, dout_valid, dout_ovf.
//   slave : the MAC unit.
interface cnn_mac_pipe_sat_if #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 9,
  parameter int DOUT_WIDTH = 16
) ();
  logic                         ce;
  logic                         in_valid;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         first;
  logic                         last;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ovf;

  modport master (
    output ce, in_valid, din0, din1, first, last,
    input  dout, dout_valid, dout_ovf
  );

  modport slave (
    input  ce, in_valid, din0, din1, first, last,
    output dout, dout_valid, dout_ovf
  );
endinterface

// File: rtl/cnn_mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with framed (first/last) accumulation,
// saturating accumulator, and round/shift/saturate fixed-point output.
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : cnn_mac_pipe_sat_if.slave (ce, in_valid, din0, din1, first, last in;
//            dout, dout_valid, dout_ovf out)
// Pipeline: operand reg -> (MUL_STAGE-1) product regs -> accumulator -> output reg.
module cnn_mac_pipe_sat #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int MUL_STAGE  = 2
) (
  input logic               ap_clk,
  input logic               ap_rst,
  cnn_mac_pipe_sat_if.slave bus
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW:0] RND = (FRAC_SHIFT > 0) ? ((AW+1)'(1) << RND_SH) : '0;
  localparam logic signed [AW:0] DMAX = {{(AW+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] DMIN = {{(AW+2-DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // Operand registers and side-band (valid/first/last) shift chain
  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic [MUL_STAGE-1:0]         vld_q, fst_q, lst_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else if (bus.ce) begin
      a_q      <= bus.din0;
      b_q      <= bus.din1;
      vld_q[0] <= bus.in_valid;
      fst_q[0] <= bus.first;
      lst_q[0] <= bus.last;
      for (int i = 1; i < MUL_STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
        fst_q[i] <= fst_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  // Full-width signed product, then optional product register stages
  logic signed [PW-1:0] prod_full, mul_out;
  assign prod_full = PW'(a_q) * PW'(b_q);

  if (MUL_STAGE == 1) begin : g_mul_comb
    assign mul_out = prod_full;
  end else begin : g_mul_pipe
    logic signed [PW-1:0] prod_q [MUL_STAGE-1];
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        for (int i = 0; i < MUL_STAGE - 1; i++) prod_q[i] <= '0;
      end else if (bus.ce) begin
        prod_q[0] <= prod_full;
        for (int i = 1; i < MUL_STAGE - 1; i++) prod_q[i] <= prod_q[i-1];
      end
    end
    assign mul_out = prod_q[MUL_STAGE-2];
  end

  logic m_vld, m_fst, m_lst;
  assign m_vld = vld_q[MUL_STAGE-1];
  assign m_fst = fst_q[MUL_STAGE-1];
  assign m_lst = lst_q[MUL_STAGE-1];

  // Accumulate stage
  logic signed [AW-1:0] p_ext, acc_q, acc_d;
  logic signed [AW:0]   sum;
  logic                 sum_ovf, ovf_q, ovf_d, fin_q;

  always_comb begin
    p_ext   = AW'(mul_out);
    sum     = (AW+1)'(acc_q) + (AW+1)'(p_ext);
    // Signed overflow: the carry-out bit disagrees with the ACC sign bit
    sum_ovf = sum[AW] ^ sum[AW-1];
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (m_vld) begin
      if (m_fst) begin
        acc_d = p_ext;
        ovf_d = 1'b0;
      end else if (sum_ovf) begin
        // Overflow only happens when both operands share a sign, so p picks the rail
        acc_d = p_ext[AW-1] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[AW-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (bus.ce) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      fin_q <= m_vld & m_lst;
    end
  end

  // Output stage: round half up, arithmetic shift, saturate to DOUT range
  logic signed [AW:0]           rnd, shr;
  logic signed [DOUT_WIDTH-1:0] sat, dout_q;
  logic                         dout_valid_q, dout_ovf_q;

  always_comb begin
    rnd = (AW+1)'(acc_q) + RND;
    shr = rnd >>> FRAC_SHIFT;
    if (shr > DMAX) begin
      sat = DMAX[DOUT_WIDTH-1:0];
    end else if (shr < DMIN) begin
      sat = DMIN[DOUT_WIDTH-1:0];
    end else begin
      sat = shr[DOUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
    end else if (bus.ce) begin
      dout_valid_q <= fin_q;
      if (fin_q) begin
        dout_q     <= sat;
        dout_ovf_q <= ovf_q;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_ovf   = dout_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Directed bench for cnn_mac_pipe_sat with default parameters.
module tb_cnn_mac_pipe_sat;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_mac_pipe_sat_if bus ();

  cnn_mac_pipe_sat dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_edge = 0;

  logic signed [15:0] q_dout [$];
  logic               q_ovf  [$];
  int                 q_edge [$];

  // Record every result pulse seen on an enabled edge
  always @(posedge clk) begin
    logic en;
    en = bus.ce;
    edge_n++;
    #1;
    if (en && bus.dout_valid) begin
      q_dout.push_back(bus.dout);
      q_ovf.push_back(bus.dout_ovf);
      q_edge.push_back(edge_n);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic v, input int a, input int b, input logic f, input logic l);
    bus.in_valid = v;
    bus.din0     = 14'(a);
    bus.din1     = 9'(b);
    bus.first    = f;
    bus.last     = l;
    if (v && l && bus.ce) last_edge = edge_n + 1;
    tick();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.first    = 1'b0;
    bus.last     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    q_dout.delete();
    q_ovf.delete();
    q_edge.delete();
  endtask

  task automatic group(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) beat(1'b1, a, b, i == 0, i == n - 1);
    idle(6);
  endtask

  task automatic expect_one(input string tag, input int d, input logic o, input int lat);
    chk({tag, "_count"}, q_dout.size(), 1);
    if (q_dout.size() >= 1) begin
      chk({tag, "_dout"}, q_dout[0], d);
      chk({tag, "_ovf"}, q_ovf[0], o);
      chk({tag, "_lat"}, q_edge[0], last_edge + lat);
    end
    clr();
  endtask

  initial begin
    rst          = 1'b1;
    bus.ce       = 1'b1;
    bus.in_valid = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    bus.first    = 1'b0;
    bus.last     = 1'b0;
    idle(3);
    rst = 1'b0;
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_ovf", bus.dout_ovf, 0);
    clr();

    // Single-beat group: (2088705 + 128) >> 8 = 8159
    group(1, 8191, 255);
    expect_one("single", 8159, 1'b0, 3);

    // 256 * (1+2+3+4) = 2560 -> 10
    for (int i = 1; i <= 4; i++) beat(1'b1, 256, i, i == 1, i == 4);
    idle(6);
    expect_one("four", 10, 1'b0, 3);

    // Output saturation without accumulator overflow
    group(128, 8191, 255);
    expect_one("pos_sat", 32767, 1'b0, 3);
    group(128, -8192, 255);
    expect_one("neg_sat", -32768, 1'b0, 3);

    // Accumulator clamps at 2^31-1, next group starts clean
    group(1100, 8191, 255);
    expect_one("acc_clamp", 32767, 1'b1, 3);
    group(1, 256, 4);
    expect_one("after_clamp", 4, 1'b0, 3);

    // Bubbles in the group, then ce=0 for 3 cycles with junk inputs presented
    beat(1'b1, 256, 1, 1'b1, 1'b0);
    beat(1'b1, 256, 2, 1'b0, 1'b0);
    idle(1);
    beat(1'b1, 256, 3, 1'b0, 1'b0);
    beat(1'b1, 256, 4, 1'b0, 1'b1);
    bus.ce       = 1'b0;
    bus.in_valid = 1'b1;
    bus.din0     = 14'(8191);
    bus.din1     = 9'(255);
    bus.first    = 1'b1;
    bus.last     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_dout", bus.dout, 4);
      chk("stall_valid", bus.dout_valid, 0);
    end
    bus.ce = 1'b1;
    idle(8);
    expect_one("ce_stall", 10, 1'b0, 6);

    // Reset mid-group discards it
    beat(1'b1, 256, 1, 1'b1, 1'b0);
    beat(1'b1, 256, 2, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6);
    chk("rst_mid_count", q_dout.size(), 0);
    chk("rst_mid_dout", bus.dout, 0);
    clr();
    for (int i = 1; i <= 4; i++) beat(1'b1, 256, i, i == 1, i == 4);
    idle(6);
    expect_one("after_rst", 10, 1'b0, 3);

    // Back-to-back single-beat groups
    for (int i = 1; i <= 3; i++) beat(1'b1, 512, i, 1'b1, 1'b1);
    idle(6);
    chk("b2b_count", q_dout.size(), 3);
    if (q_dout.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_dout", q_dout[i], 2 * (i + 1));
        chk("b2b_ovf", q_ovf[i], 0);
        chk("b2b_edge", q_edge[i], last_edge + 1 + i);
      end
    end
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
